// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_pkg
//  Description : Shared definitions for the RV32I non-pipelined core:
//                data width, the canonical NOP word, the instruction-fetch
//                state encoding and a word-alignment helper.
//  Revision    : 1.0  initial release
// ============================================================================
package rv32i_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    // Instruction-fetch FSM encoding
    localparam logic [1:0] S_FETCH = 2'd0;  // request outstanding at pc
    localparam logic [1:0] S_HOLD  = 2'd1;  // instruction parked for decode
    localparam logic [1:0] S_DRAIN = 2'd2;  // swallowing an abandoned response

    // Clear the byte offset of an address.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_pc_reg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pc_reg
//  Description : Program counter for the fetch unit. Loads RESET_PC on
//                reset, otherwise a redirect takes priority over the +4
//                increment. Also exposes pc+4 (modulo 2^32).
//  Ports       : clk, rst_n (sync, active low), inc_en, redirect,
//                target[31:0] -> pc[31:0], pc_inc[31:0]
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_pc_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc_en,
    input  logic        redirect,
    input  logic [31:0] target,
    output logic [31:0] pc,
    output logic [31:0] pc_inc
);
    import rv32i_pkg::*;

    logic [31:0] r_pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (redirect) begin
            r_pc <= align_word(target);
        end else if (inc_en) begin
            r_pc <= r_pc + 32'd4;
        end
    end

    assign pc     = r_pc;
    // Natural 32-bit wrap: 0xFFFF_FFFC + 4 = 0x0000_0000.
    assign pc_inc = r_pc + 32'd4;

endmodule
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_fetch_unit
//  Description : Producer side of the IF/ID interface. Sequences the PC,
//                runs a req/valid handshake with instruction memory and
//                parks each fetched word for decode under valid/ready.
//                Taken branches/jumps from execute flush the held or
//                in-flight fetch.
//  Ports       : clk, rst_n (sync, active low)
//                imem_req/imem_addr  -> instruction memory request
//                imem_valid/imem_rdata <- instruction memory response
//                IF_ID_IR/IF_ID_NPC/IF_ID_valid -> decode, ID_ready <- decode
//                br_taken/br_target  <- execute redirect
//  Revision    : 1.0  initial release
// ============================================================================
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN = rv32i_pkg::NOP_INSN
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_ID_IR,
    output logic [31:0] IF_ID_NPC,
    output logic        IF_ID_valid,
    input  logic        ID_ready,
    input  logic        br_taken,
    input  logic [31:0] br_target
);
    import rv32i_pkg::*;

    logic [1:0]  r_state;
    logic [31:0] r_ir;
    logic [31:0] r_npc;
    logic        r_valid;
    logic [31:0] r_drain_addr;   // address of the request being abandoned

    logic [31:0] w_pc;
    logic [31:0] w_pc_inc;
    logic        w_accept;

    // A response is taken only in S_FETCH and only when no redirect competes.
    assign w_accept = (r_state == S_FETCH) && imem_valid && !br_taken;

    fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc_en   (w_accept),
        .redirect (br_taken),
        .target   (br_target),
        .pc       (w_pc),
        .pc_inc   (w_pc_inc)
    );

    // Request depends only on state and reset, never on decode or execute.
    assign imem_req  = rst_n && ((r_state == S_FETCH) || (r_state == S_DRAIN));
    // While draining, the memory still owes us the old address; keep it
    // stable even though pc already points at the redirect target.
    assign imem_addr = (r_state == S_DRAIN) ? r_drain_addr : w_pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_FETCH;
            r_ir         <= NOP_INSN;
            r_npc        <= RESET_PC;
            r_valid      <= 1'b0;
            r_drain_addr <= RESET_PC;
        end else if (br_taken) begin
            r_valid <= 1'b0;
            r_ir    <= NOP_INSN;
            case (r_state)
                S_FETCH: begin
                    // A same-cycle response is simply dropped; otherwise the
                    // outstanding request must be drained first.
                    if (!imem_valid) begin
                        r_state      <= S_DRAIN;
                        r_drain_addr <= w_pc;
                    end
                end
                S_HOLD:  r_state <= S_FETCH;
                S_DRAIN: r_state <= S_DRAIN;
                default: r_state <= S_FETCH;
            endcase
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (imem_valid) begin
                        r_ir    <= imem_rdata;
                        r_npc   <= w_pc_inc;
                        r_valid <= 1'b1;
                        r_state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (ID_ready) begin
                        r_valid <= 1'b0;
                        r_ir    <= NOP_INSN;
                        r_state <= S_FETCH;
                    end
                end
                S_DRAIN: begin
                    if (imem_valid) begin
                        r_state <= S_FETCH;
                    end
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end

    assign IF_ID_IR    = r_ir;
    assign IF_ID_NPC   = r_npc;
    assign IF_ID_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instruction_fetch_unit
//  Description : Self-checking bench for instruction_fetch_unit. A memory
//                model with programmable latency answers requests; a
//                transaction-level reference model predicts the IF/ID
//                outputs and the request stream. A second instance with a
//                wrapping reset PC runs against a zero-wait memory.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_instruction_fetch_unit;

    localparam logic [31:0] C_NOP      = 32'h0000_0013;
    localparam logic [31:0] C_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] C_WRAP_PC  = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] IF_ID_IR;
    logic [31:0] IF_ID_NPC;
    logic        IF_ID_valid;
    logic        ID_ready = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = 32'h0;

    // Wrap instance: zero-wait memory, decode always ready, no redirects.
    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_ir;
    logic [31:0] w_npc;
    logic        w_valid;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    instruction_fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_valid  (imem_valid),
        .imem_rdata  (imem_rdata),
        .IF_ID_IR    (IF_ID_IR),
        .IF_ID_NPC   (IF_ID_NPC),
        .IF_ID_valid (IF_ID_valid),
        .ID_ready    (ID_ready),
        .br_taken    (br_taken),
        .br_target   (br_target)
    );

    instruction_fetch_unit #(
        .RESET_PC (C_WRAP_PC)
    ) dut_wrap (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (w_req),
        .imem_addr   (w_addr),
        .imem_valid  (w_req),
        .imem_rdata  (memf(w_addr)),
        .IF_ID_IR    (w_ir),
        .IF_ID_NPC   (w_npc),
        .IF_ID_valid (w_valid),
        .ID_ready    (1'b1),
        .br_taken    (1'b0),
        .br_target   (32'h0)
    );

    // Reference model: what decode should be holding and what memory owes.
    logic [31:0] m_pc      = C_RESET_PC;
    logic        m_valid   = 1'b0;
    logic [31:0] m_ir      = C_NOP;
    logic [31:0] m_npc     = C_RESET_PC;
    logic        m_drain   = 1'b0;
    logic [31:0] m_drop    = 32'h0;

    // Memory latency control: cycles until the pending request is answered.
    int lat       = 0;
    int fixed_lat = 0;   // < 0 selects random latency 0..3

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic rdy, input logic br,
                              input logic [31:0] tgt, input logic mv);
        if (!r) begin
            m_pc = C_RESET_PC; m_valid = 1'b0; m_ir = C_NOP;
            m_npc = C_RESET_PC; m_drain = 1'b0;
        end else if (br) begin
            // A request still unanswered at redirect time must be swallowed.
            if (!m_valid && !m_drain && !mv) begin
                m_drain = 1'b1;
                m_drop  = m_pc;
            end
            m_pc = tgt & ~32'h3; m_valid = 1'b0; m_ir = C_NOP;
        end else if (m_drain) begin
            if (mv) m_drain = 1'b0;
        end else if (m_valid) begin
            if (rdy) begin m_valid = 1'b0; m_ir = C_NOP; end
        end else if (mv) begin
            m_ir = memf(m_pc); m_npc = m_pc + 32'd4; m_pc = m_pc + 32'd4;
            m_valid = 1'b1;
        end
    endtask

    // One clock: drive inputs at negedge, advance model at posedge,
    // compare at the following negedge.
    task automatic cycle(input logic r, input logic rdy, input logic br, input logic [31:0] tgt);
        logic exp_req;
        rst_n = r; ID_ready = rdy; br_taken = br; br_target = tgt;
        #1;
        imem_rdata = $urandom;
        imem_valid = 1'b0;
        if (!r) begin
            lat = 0;
        end else if (imem_req) begin
            if (lat == 0) begin
                imem_valid = 1'b1;
                imem_rdata = memf(imem_addr);
                lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
            end else begin
                lat--;
            end
        end
        @(posedge clk);
        model_edge(r, rdy, br, tgt, imem_valid);
        @(negedge clk);
        exp_req = rst_n && !m_valid;
        chk("valid", {31'h0, IF_ID_valid}, {31'h0, m_valid});
        chk("ir", IF_ID_IR, m_ir);
        chk("npc", IF_ID_NPC, m_npc);
        chk("req", {31'h0, imem_req}, {31'h0, exp_req});
        if (exp_req) chk("addr", imem_addr, m_drain ? m_drop : m_pc);
    endtask

    initial begin
        @(negedge clk);

        // T1: reset two cycles, zero-wait memory, decode always ready
        fixed_lat = 0;
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        chk("rst_ir", IF_ID_IR, C_NOP);
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        rst_n = 1'b1;
        #1;
        chk("t1_addr0", imem_addr, 32'h0);
        chk("t5_addr0", w_addr, C_WRAP_PC);
        chk("t5_req0", {31'h0, w_req}, 32'h1);
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        chk("t1_ir", IF_ID_IR, memf(32'h0));
        chk("t1_npc", IF_ID_NPC, 32'h4);
        chk("t5_ir", w_ir, memf(C_WRAP_PC));
        chk("t5_npc", w_npc, 32'h0);
        chk("t5_valid", {31'h0, w_valid}, 32'h1);
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        chk("t1_addr4", imem_addr, 32'h4);
        chk("t5_addr1", w_addr, 32'h0);

        // T2: decode stalls for five cycles with an instruction held
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        repeat (5) cycle(1'b1, 1'b0, 1'b0, 32'h0);
        chk("t2_npc", IF_ID_NPC, 32'h8);
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        chk("t2_addr", imem_addr, 32'h8);

        // T3: redirect while holding, decode ready in the same cycle
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 1'b1, 32'h0000_0103);
        chk("t3_valid", {31'h0, IF_ID_valid}, 32'h0);
        chk("t3_addr", imem_addr, 32'h0000_0100);

        // T4: three-cycle memory, redirect on the first request cycle
        lat = 3;
        cycle(1'b1, 1'b1, 1'b1, 32'h0000_0200);
        repeat (3) cycle(1'b1, 1'b1, 1'b0, 32'h0);
        chk("t4_addr", imem_addr, 32'h0000_0200);
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        chk("t4_ir", IF_ID_IR, memf(32'h0000_0200));

        // T6: reset asserted while draining
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        lat = 3;
        cycle(1'b1, 1'b1, 1'b1, 32'h0000_0444);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        chk("t6_npc", IF_ID_NPC, C_RESET_PC);
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        chk("t6_ir", IF_ID_IR, memf(C_RESET_PC));

        // Random traffic: latencies, stalls, redirects, occasional reset
        fixed_lat = -1;
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 63) != 0),
                  ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 7) == 0),
                  $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
